// File: rtl/multicycle_controller.sv
// Multi-cycle instruction controller for the SimpleCPU.
// Fetches an instruction over a req/ready handshake, decodes the opcode
// and sequences ADD, LOAD, STORE, JMP, JZ, HALT and illegal-opcode handling,
// driving one-cycle strobes toward the datapath.
module multicycle_controller #(
  parameter int DATA_W = 8,
  parameter int OPC_W  = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  input  logic              zero_flag,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic              sum_en,
  output logic              load_en,
  output logic              store_en,
  output logic              illegal,
  output logic              halted
);

  localparam int OPND_W = DATA_W - OPC_W;

  localparam logic [OPC_W-1:0] OPC_ADD   = OPC_W'(4'b0000);
  localparam logic [OPC_W-1:0] OPC_STORE = OPC_W'(4'b0010);
  localparam logic [OPC_W-1:0] OPC_LOAD  = OPC_W'(4'b0100);
  localparam logic [OPC_W-1:0] OPC_JMP   = OPC_W'(4'b0110);
  localparam logic [OPC_W-1:0] OPC_JZ    = OPC_W'(4'b1000);
  localparam logic [OPC_W-1:0] OPC_HALT  = OPC_W'(4'b1111);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  state_t              state_r;
  state_t              next_state_s;
  logic [ADDR_W-1:0]   pc_r;
  logic [ADDR_W-1:0]   pc_next_s;
  logic [DATA_W-1:0]   ir_r;
  logic [DATA_W-1:0]   ir_next_s;
  logic                illegal_r;
  logic                illegal_set_s;
  logic                halted_r;

  logic [OPC_W-1:0]    opc_s;
  logic [OPND_W-1:0]   operand_s;
  logic [ADDR_W-1:0]   target_s;
  logic                is_load_s;
  logic                is_store_s;

  logic                mem_req_s;
  logic                mem_we_s;
  logic [ADDR_W-1:0]   mem_addr_s;
  logic                sum_en_s;
  logic                load_en_s;
  logic                store_en_s;

  // Operand to address: zero-extend when narrower, keep low bits when wider.
  function automatic logic [ADDR_W-1:0] fit_addr(input logic [OPND_W-1:0] opnd);
    return ADDR_W'(opnd);
  endfunction

  assign opc_s      = ir_r[DATA_W-1 -: OPC_W];
  assign operand_s  = ir_r[OPND_W-1:0];
  assign target_s   = fit_addr(operand_s);
  assign is_load_s  = (opc_s == OPC_LOAD);
  assign is_store_s = (opc_s == OPC_STORE);

  // State, program counter, instruction register and sticky status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_FETCH;
      pc_r      <= '0;
      ir_r      <= '0;
      illegal_r <= 1'b0;
      halted_r  <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      pc_r      <= pc_next_s;
      ir_r      <= ir_next_s;
      illegal_r <= illegal_r | illegal_set_s;
      halted_r  <= (next_state_s == ST_HALT);
    end
  end

  // Next-state, register updates and handshake/strobe decode per state.
  always_comb begin
    next_state_s  = state_r;
    pc_next_s     = pc_r;
    ir_next_s     = ir_r;
    illegal_set_s = 1'b0;
    mem_req_s     = 1'b0;
    mem_we_s      = 1'b0;
    mem_addr_s    = pc_r;
    sum_en_s      = 1'b0;
    load_en_s     = 1'b0;
    store_en_s    = 1'b0;
    case (state_r)
      ST_FETCH: begin
        mem_req_s = 1'b1;
        if (mem_ready) begin
          ir_next_s    = mem_rdata;
          pc_next_s    = pc_r + ADDR_W'(1'b1);
          next_state_s = ST_DECODE;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        case (opc_s)
          OPC_ADD:   next_state_s = ST_EXEC;
          OPC_LOAD:  next_state_s = ST_MEM;
          OPC_STORE: next_state_s = ST_MEM;
          OPC_JMP: begin
            pc_next_s    = target_s;
            next_state_s = ST_FETCH;
          end
          OPC_JZ: begin
            if (zero_flag) begin
              pc_next_s = target_s;
            end else begin
              pc_next_s = pc_r;
            end
            next_state_s = ST_FETCH;
          end
          OPC_HALT:  next_state_s = ST_HALT;
          default: begin
            illegal_set_s = 1'b1;
            next_state_s  = ST_FETCH;
          end
        endcase
      end
      ST_EXEC: begin
        sum_en_s     = 1'b1;
        next_state_s = ST_FETCH;
      end
      ST_MEM: begin
        mem_req_s  = 1'b1;
        mem_addr_s = target_s;
        mem_we_s   = is_store_s;
        load_en_s  = is_load_s & mem_ready;
        store_en_s = is_store_s & mem_ready;
        if (mem_ready) begin
          next_state_s = ST_FETCH;
        end else begin
          next_state_s = ST_MEM;
        end
      end
      ST_HALT: begin
        next_state_s = ST_HALT;
      end
      default: begin
        next_state_s = ST_FETCH;
      end
    endcase
  end

  // Reset forces every request and strobe low immediately, whatever the state.
  assign mem_req  = mem_req_s & ~rst;
  assign mem_we   = mem_we_s & ~rst;
  assign sum_en   = sum_en_s & ~rst;
  assign load_en  = load_en_s & ~rst;
  assign store_en = store_en_s & ~rst;
  assign mem_addr = mem_addr_s;
  assign pc       = pc_r;
  assign ir       = ir_r;
  assign illegal  = illegal_r;
  assign halted   = halted_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: each task drives one
// instruction scenario, pushes its expected outcome to a scoreboard queue and
// pops/compares it against per-cycle observations.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] mem_rdata;
  logic       mem_ready;
  logic       zero_flag;
  logic       mem_req;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [3:0] pc;
  logic [7:0] ir;
  logic       sum_en;
  logic       load_en;
  logic       store_en;
  logic       illegal;
  logic       halted;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] next_pc;
    int         n_sum;
    int         n_load;
    int         n_store;
    logic       we;
    logic [3:0] maddr;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  logic       req_a     [0:31];
  logic       we_a      [0:31];
  logic [3:0] addr_a    [0:31];
  logic [3:0] pc_a      [0:31];
  logic       sum_a     [0:31];
  logic       load_a    [0:31];
  logic       store_a   [0:31];
  logic       illegal_a [0:31];
  logic       halted_a  [0:31];
  int         obs_sum, obs_load, obs_store;
  logic       obs_multi;

  multicycle_controller #(.DATA_W(8), .OPC_W(4), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .zero_flag(zero_flag), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .pc(pc), .ir(ir), .sum_en(sum_en),
    .load_en(load_en), .store_en(store_en), .illegal(illegal),
    .halted(halted)
  );

  always #5 clk = ~clk;

  // Drive one instruction: cycle 0 is its FETCH, memory phase (if any) starts
  // at cycle 2 and completes after 'waits' wait cycles; cycle ncyc is sampled
  // but not advanced (it is the next FETCH, with ready held low).
  task automatic run_instr(input logic [7:0] instr, input int waits,
                           input logic zf, input int ncyc);
    obs_sum = 0; obs_load = 0; obs_store = 0; obs_multi = 1'b0;
    for (int k = 0; k <= ncyc; k++) begin
      zero_flag = zf;
      mem_rdata = (k == 0) ? instr : 8'h00;
      mem_ready = (k < ncyc) && ((k == 0) || (k >= 2 + waits));
      #1;
      req_a[k] = mem_req;   we_a[k] = mem_we;     addr_a[k] = mem_addr;
      pc_a[k] = pc;         sum_a[k] = sum_en;    load_a[k] = load_en;
      store_a[k] = store_en; illegal_a[k] = illegal; halted_a[k] = halted;
      obs_sum   += int'(sum_en);
      obs_load  += int'(load_en);
      obs_store += int'(store_en);
      if (int'(sum_en) + int'(load_en) + int'(store_en) > 1) obs_multi = 1'b1;
      if (k < ncyc) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; mem_rdata = 8'h00; zero_flag = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %0b want 0", mem_req); end
    checks++;
    if ({sum_en, load_en, store_en, mem_we} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes got %b want 0000", {sum_en, load_en, store_en, mem_we});
    end
    checks++;
    if ({pc, ir, illegal, halted} !== 14'h0) begin
      errors++; $display("FAIL reset_regs got pc=%0d ir=%h ill=%0b halt=%0b want zeros", pc, ir, illegal, halted);
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    sb.push_back('{next_pc: 4'd1, n_sum: 1, n_load: 0, n_store: 0, we: 1'b0, maddr: 4'd0});
    run_instr(8'h05, 0, 1'b0, 3);
    e = sb.pop_front();
    checks++;
    if (req_a[0] !== 1'b1 || addr_a[0] !== 4'd0 || we_a[0] !== 1'b0) begin
      errors++; $display("FAIL add_fetch got req=%0b addr=%0d we=%0b want 1/0/0", req_a[0], addr_a[0], we_a[0]);
    end
    checks++;
    if (req_a[1] !== 1'b0 || addr_a[1] !== pc_a[1]) begin
      errors++; $display("FAIL add_decode got req=%0b addr=%0d want 0/%0d", req_a[1], addr_a[1], pc_a[1]);
    end
    checks++;
    if (sum_a[2] !== 1'b1 || obs_sum != e.n_sum || obs_load != e.n_load || obs_store != e.n_store) begin
      errors++; $display("FAIL add_sum got sum@2=%0b counts=%0d/%0d/%0d want 1 and %0d/%0d/%0d",
                         sum_a[2], obs_sum, obs_load, obs_store, e.n_sum, e.n_load, e.n_store);
    end
    checks++;
    if (req_a[3] !== 1'b1 || addr_a[3] !== e.next_pc || pc_a[3] !== e.next_pc) begin
      errors++; $display("FAIL add_next got req=%0b addr=%0d pc=%0d want 1/%0d", req_a[3], addr_a[3], pc_a[3], e.next_pc);
    end
  endtask

  task automatic test_load_wait();
    sb.push_back('{next_pc: 4'd2, n_sum: 0, n_load: 1, n_store: 0, we: 1'b0, maddr: 4'd9});
    run_instr(8'h49, 2, 1'b0, 5);
    e = sb.pop_front();
    for (int k = 2; k <= 4; k++) begin
      checks++;
      if (req_a[k] !== 1'b1 || addr_a[k] !== e.maddr || we_a[k] !== e.we) begin
        errors++; $display("FAIL load_hold cyc%0d got req=%0b addr=%0d we=%0b want 1/%0d/%0b",
                           k, req_a[k], addr_a[k], we_a[k], e.maddr, e.we);
      end
    end
    checks++;
    if (load_a[4] !== 1'b1 || obs_load != e.n_load || obs_sum != e.n_sum || obs_store != e.n_store) begin
      errors++; $display("FAIL load_strobe got load@ready=%0b counts=%0d/%0d/%0d want 1 and %0d/%0d/%0d",
                         load_a[4], obs_sum, obs_load, obs_store, e.n_sum, e.n_load, e.n_store);
    end
    checks++;
    if (req_a[5] !== 1'b1 || we_a[5] !== 1'b0 || addr_a[5] !== e.next_pc) begin
      errors++; $display("FAIL load_next got req=%0b we=%0b addr=%0d want 1/0/%0d", req_a[5], we_a[5], addr_a[5], e.next_pc);
    end
  endtask

  task automatic test_store();
    sb.push_back('{next_pc: 4'd3, n_sum: 0, n_load: 0, n_store: 1, we: 1'b1, maddr: 4'd10});
    run_instr(8'h2A, 0, 1'b0, 3);
    e = sb.pop_front();
    checks++;
    if (req_a[2] !== 1'b1 || we_a[2] !== e.we || addr_a[2] !== e.maddr || store_a[2] !== 1'b1) begin
      errors++; $display("FAIL store_mem got req=%0b we=%0b addr=%0d st=%0b want 1/%0b/%0d/1",
                         req_a[2], we_a[2], addr_a[2], store_a[2], e.we, e.maddr);
    end
    checks++;
    if (obs_store != e.n_store || obs_sum != e.n_sum || obs_load != e.n_load || obs_multi !== 1'b0) begin
      errors++; $display("FAIL store_counts got %0d/%0d/%0d multi=%0b want %0d/%0d/%0d multi=0",
                         obs_sum, obs_load, obs_store, obs_multi, e.n_sum, e.n_load, e.n_store);
    end
    checks++;
    if (addr_a[3] !== e.next_pc || we_a[3] !== 1'b0) begin
      errors++; $display("FAIL store_next got addr=%0d we=%0b want %0d/0", addr_a[3], we_a[3], e.next_pc);
    end
  endtask

  task automatic test_jumps();
    logic [7:0] instr_t [3] = '{8'h6C, 8'h83, 8'h83};
    logic       zf_t    [3] = '{1'b0, 1'b0, 1'b1};
    logic [3:0] pc_t    [3] = '{4'd12, 4'd13, 4'd3};
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{next_pc: pc_t[i], n_sum: 0, n_load: 0, n_store: 0, we: 1'b0, maddr: 4'd0});
    end
    for (int i = 0; i < 3; i++) begin
      run_instr(instr_t[i], 0, zf_t[i], 2);
      e = sb.pop_front();
      checks++;
      if (req_a[2] !== 1'b1 || addr_a[2] !== e.next_pc || pc_a[2] !== e.next_pc || obs_sum + obs_load + obs_store != 0) begin
        errors++; $display("FAIL jump%0d got req=%0b addr=%0d pc=%0d strobes=%0d want 1/%0d/%0d/0",
                           i, req_a[2], addr_a[2], pc_a[2], obs_sum + obs_load + obs_store, e.next_pc, e.next_pc);
      end
    end
  endtask

  task automatic test_illegal();
    sb.push_back('{next_pc: 4'd4, n_sum: 0, n_load: 0, n_store: 0, we: 1'b0, maddr: 4'd0});
    sb.push_back('{next_pc: 4'd5, n_sum: 1, n_load: 0, n_store: 0, we: 1'b0, maddr: 4'd0});
    checks++;
    if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_pre got %0b want 0", illegal); end
    run_instr(8'h17, 0, 1'b0, 2);
    e = sb.pop_front();
    checks++;
    if (illegal_a[2] !== 1'b1 || addr_a[2] !== e.next_pc || obs_sum + obs_load + obs_store != 0) begin
      errors++; $display("FAIL illegal_set got ill=%0b addr=%0d strobes=%0d want 1/%0d/0",
                         illegal_a[2], addr_a[2], obs_sum + obs_load + obs_store, e.next_pc);
    end
    run_instr(8'h01, 0, 1'b0, 3);
    e = sb.pop_front();
    checks++;
    if (illegal_a[3] !== 1'b1 || addr_a[3] !== e.next_pc || obs_sum != e.n_sum) begin
      errors++; $display("FAIL illegal_sticky got ill=%0b addr=%0d sum=%0d want 1/%0d/%0d",
                         illegal_a[3], addr_a[3], obs_sum, e.next_pc, e.n_sum);
    end
  endtask

  task automatic test_wrap();
    sb.push_back('{next_pc: 4'd0, n_sum: 1, n_load: 0, n_store: 0, we: 1'b0, maddr: 4'd0});
    run_instr(8'h6F, 0, 1'b0, 2);
    run_instr(8'h00, 0, 1'b0, 3);
    e = sb.pop_front();
    checks++;
    if (addr_a[0] !== 4'd15 || addr_a[3] !== e.next_pc || pc_a[3] !== e.next_pc || obs_sum != e.n_sum) begin
      errors++; $display("FAIL wrap got fetch=%0d next=%0d pc=%0d sum=%0d want 15/%0d/%0d/%0d",
                         addr_a[0], addr_a[3], pc_a[3], obs_sum, e.next_pc, e.next_pc, e.n_sum);
    end
  endtask

  task automatic test_reset_mid();
    run_instr(8'h49, 5, 1'b0, 3);
    checks++;
    if (req_a[3] !== 1'b1 || addr_a[3] !== 4'd9) begin
      errors++; $display("FAIL midrst_wait got req=%0b addr=%0d want 1/9", req_a[3], addr_a[3]);
    end
    mem_ready = 1'b1;
    rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || load_en !== 1'b0 || pc !== 4'd0 || illegal !== 1'b0) begin
      errors++; $display("FAIL midrst_abort got req=%0b load=%0b pc=%0d ill=%0b want 0/0/0/0", mem_req, load_en, pc, illegal);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 4'd0) begin
      errors++; $display("FAIL midrst_restart got req=%0b we=%0b addr=%0d want 1/0/0", mem_req, mem_we, mem_addr);
    end
  endtask

  task automatic test_halt();
    run_instr(8'hF0, 0, 1'b0, 2);
    checks++;
    if (halted_a[2] !== 1'b1 || req_a[2] !== 1'b0 || halted_a[1] !== 1'b0) begin
      errors++; $display("FAIL halt_enter got halt@1=%0b halt@2=%0b req=%0b want 0/1/0", halted_a[1], halted_a[2], req_a[2]);
    end
    mem_ready = 1'b1;
    mem_rdata = 8'h05;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (halted !== 1'b1 || mem_req !== 1'b0 || pc !== 4'd1 || {sum_en, load_en, store_en} !== 3'b000) begin
        errors++; $display("FAIL halt_hold cyc%0d got halt=%0b req=%0b pc=%0d strobes=%b want 1/0/1/000",
                           k, halted, mem_req, pc, {sum_en, load_en, store_en});
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_wait();
    test_store();
    test_jumps();
    test_illegal();
    test_wrap();
    test_reset_mid();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
